// File: rtl/cache_assoc_wb.sv
// cache_assoc_wb: 2-way set-associative write-back, write-allocate cache, one word per line.
// Optional CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
module cache_assoc_wb #(
  parameter int DATA_W = 8,
  parameter int IDX_W = 2,
  parameter int TAG_W = 3,
  localparam int ADDR_W = TAG_W + IDX_W,
  localparam int SETS = 2 ** IDX_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_wren,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              hit,
  output logic              writeBack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);
  typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, REFILL, RESP} state_t;
  state_t state, nxt;
  logic [SETS-1:0] valid [2];
  logic [SETS-1:0] dirty [2];
  logic [TAG_W-1:0] tags [2][SETS];
  logic [DATA_W-1:0] data [2][SETS];
  logic [SETS-1:0] lru;
  logic r_wren, hit_r, wb_r, way;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tg;
  logic h0, h1, hit_any, vic, vic_dirty, wr_line, wr_way;
  assign idx = r_addr[IDX_W-1:0];
  assign tg = r_addr[ADDR_W-1:IDX_W];
  assign h0 = valid[0][idx] && tags[0][idx] == tg;
  assign h1 = valid[1][idx] && tags[1][idx] == tg;
  assign hit_any = h0 || h1;
  assign vic = !valid[0][idx] ? 1'b0 : !valid[1][idx] ? 1'b1 : lru[idx];
  assign vic_dirty = valid[vic][idx] && dirty[vic][idx];
  assign wr_way = state == LOOKUP ? (hit_any ? h1 : vic) : way;
  assign cpu_ready = state == IDLE && !reset;
  assign cpu_done = state == RESP;
  assign hit = cpu_done && hit_r;
  assign writeBack = cpu_done && wb_r;
  assign mem_req = state == WRITEBACK || state == REFILL;
  assign mem_we = state == WRITEBACK;
  always_ff @(posedge clock)
    state <= reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    wr_line = 1'b0;
    unique case (state)
      IDLE: nxt = cpu_req ? LOOKUP : IDLE;
      LOOKUP: begin
        nxt = hit_any ? RESP : vic_dirty ? WRITEBACK : r_wren ? RESP : REFILL;
        wr_line = r_wren && (hit_any || !vic_dirty);
      end
      WRITEBACK: begin
        nxt = mem_ack ? (r_wren ? RESP : REFILL) : WRITEBACK;
        wr_line = mem_ack && r_wren;
      end
      REFILL: begin
        nxt = mem_ack ? RESP : REFILL;
        wr_line = mem_ack;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      valid[0] <= '0;
      valid[1] <= '0;
      dirty[0] <= '0;
      dirty[1] <= '0;
      lru <= '0;
      r_wren <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
      hit_r <= 1'b0;
      wb_r <= 1'b0;
      way <= 1'b0;
      cpu_rdata <= '0;
      mem_addr <= '0;
      mem_wdata <= '0;
    end else begin
      if (cpu_req && cpu_ready) begin
        r_wren <= cpu_wren;
        r_addr <= cpu_addr;
        r_wdata <= cpu_wdata;
      end
      if (state == LOOKUP) begin
        hit_r <= hit_any;
        wb_r <= !hit_any && vic_dirty;
        way <= wr_way;
        if (hit_any && !r_wren) cpu_rdata <= data[h1][idx];
        if (!hit_any) begin
          mem_addr <= vic_dirty ? {tags[vic][idx], idx} : r_addr;
          mem_wdata <= data[vic][idx];
        end
      end
      // a dirty victim goes out first, then the refill targets the request address
      if (state == WRITEBACK && mem_ack) mem_addr <= r_addr;
      if (state == REFILL && mem_ack) cpu_rdata <= mem_rdata;
      if (wr_line) begin
        valid[wr_way][idx] <= 1'b1;
        dirty[wr_way][idx] <= state != REFILL;
        tags[wr_way][idx] <= tg;
        data[wr_way][idx] <= state == REFILL ? mem_rdata : r_wdata;
      end
      if (state == RESP) lru[idx] <= ~way;
    end
  end
`ifdef CACHE_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      hit_count <= '0;
      miss_count <= '0;
    end else if (state == RESP) begin
      if (hit_r && hit_count != 16'hFFFF) hit_count <= hit_count + 16'd1;
      if (!hit_r && miss_count != 16'hFFFF) miss_count <= miss_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_cache_assoc_wb.sv
// tb_cache_assoc_wb: table-driven directed test of cache_assoc_wb plus reset-in-refill sequence.
module tb_cache_assoc_wb;
  logic clock = 1'b0, reset = 1'b1;
  logic cpu_req = 1'b0, cpu_wren = 1'b0;
  logic [4:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic cpu_ready, cpu_done, hit, writeBack, mem_req, mem_we;
  logic [7:0] cpu_rdata, mem_wdata;
  logic [4:0] mem_addr;
  logic mem_ack = 1'b0;
  logic [7:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif
  int n_chk = 0, n_fail = 0;

  cache_assoc_wb dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wren(cpu_wren), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_rdata(cpu_rdata), .hit(hit), .writeBack(writeBack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic we; logic [4:0] a; logic [7:0] wd; logic [7:0] md; int dly;
    logic [7:0] rd; logic h; logic wb; int lat; int nr; int nw;
    logic [4:0] ra; logic [4:0] wa; logic [7:0] wdat;
  } vec_t;

  vec_t v [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one request at a negedge while idle, acts as backing memory, returns observations.
  task automatic access(input vec_t t, output vec_t r, output int bad, output logic pulse_ok);
    int cnt;
    logic preq, pwe, acked;
    logic [4:0] pa;
    logic [7:0] pwd;
    r = t; r.nr = 0; r.nw = 0; r.lat = -1; r.ra = '0; r.wa = '0; r.wdat = '0;
    r.rd = 'x; r.h = 'x; r.wb = 'x;
    bad = 0; cnt = 0; preq = 0; acked = 0; pa = '0; pwe = 0; pwd = '0; pulse_ok = 0;
    cpu_req = 1; cpu_wren = t.we; cpu_addr = t.a; cpu_wdata = t.wd;
    @(negedge clock);
    cpu_req = 0;
    for (int c = 1; c <= 60; c++) begin
      if (cpu_done) begin
        r.lat = c; r.rd = cpu_rdata; r.h = hit; r.wb = writeBack;
        break;
      end
      if (mem_req && cpu_ready) bad++;
      if (mem_req && preq && !acked && (mem_addr != pa || mem_we != pwe || mem_wdata != pwd)) bad++;
      if (mem_req && acked && mem_we == pwe) bad++;
      preq = mem_req; pa = mem_addr; pwe = mem_we; pwd = mem_wdata;
      acked = 0;
      if (mem_req && !mem_ack && cnt == t.dly) begin
        acked = 1; mem_ack = 1; mem_rdata = t.md; cnt = 0;
        if (mem_we) begin r.nw++; r.wa = mem_addr; r.wdat = mem_wdata; end
        else begin r.nr++; r.ra = mem_addr; end
      end else begin
        if (mem_req && !mem_ack) cnt++;
        mem_ack = 0;
      end
      @(negedge clock);
    end
    mem_ack = 0;
    @(negedge clock);
    pulse_ok = !cpu_done && cpu_ready;
  endtask

  task automatic run(input string n, input vec_t t);
    vec_t r;
    int bad;
    logic pulse_ok;
    access(t, r, bad, pulse_ok);
    chk({n, ".lat"}, r.lat, t.lat);
    chk({n, ".hit"}, {31'd0, r.h}, {31'd0, t.h});
    chk({n, ".wb"}, {31'd0, r.wb}, {31'd0, t.wb});
    chk({n, ".rdata"}, {24'd0, r.rd}, {24'd0, t.rd});
    chk({n, ".nread"}, r.nr, t.nr);
    chk({n, ".nwrite"}, r.nw, t.nw);
    if (t.nr > 0) chk({n, ".raddr"}, {27'd0, r.ra}, {27'd0, t.ra});
    if (t.nw > 0) begin
      chk({n, ".waddr"}, {27'd0, r.wa}, {27'd0, t.wa});
      chk({n, ".wdata"}, {24'd0, r.wdat}, {24'd0, t.wdat});
    end
    chk({n, ".handshake"}, bad, 0);
    chk({n, ".pulse"}, {31'd0, pulse_ok}, 1);
  endtask

  initial begin
    //        we  a      wd     md     dly rd     h  wb lat nr nw ra     wa     wdat
    v[0]  = '{0, 5'h05, 8'h00, 8'hA5, 0, 8'hA5, 0, 0, 3, 1, 0, 5'h05, 5'h00, 8'h00};
    v[1]  = '{0, 5'h05, 8'h00, 8'h00, 0, 8'hA5, 1, 0, 2, 0, 0, 5'h00, 5'h00, 8'h00};
    v[2]  = '{1, 5'h09, 8'h3C, 8'h00, 0, 8'hA5, 0, 0, 2, 0, 0, 5'h00, 5'h00, 8'h00};
    v[3]  = '{0, 5'h09, 8'h00, 8'h00, 0, 8'h3C, 1, 0, 2, 0, 0, 5'h00, 5'h00, 8'h00};
    v[4]  = '{1, 5'h00, 8'h11, 8'h00, 0, 8'h3C, 0, 0, 2, 0, 0, 5'h00, 5'h00, 8'h00};
    v[5]  = '{1, 5'h04, 8'h22, 8'h00, 0, 8'h3C, 0, 0, 2, 0, 0, 5'h00, 5'h00, 8'h00};
    v[6]  = '{0, 5'h08, 8'h00, 8'h77, 0, 8'h77, 0, 1, 5, 1, 1, 5'h08, 5'h00, 8'h11};
    v[7]  = '{0, 5'h04, 8'h00, 8'h00, 0, 8'h22, 1, 0, 2, 0, 0, 5'h00, 5'h00, 8'h00};
    v[8]  = '{0, 5'h08, 8'h00, 8'h00, 0, 8'h77, 1, 0, 2, 0, 0, 5'h00, 5'h00, 8'h00};
    v[9]  = '{0, 5'h0D, 8'h00, 8'h5A, 5, 8'h5A, 0, 0, 8, 1, 0, 5'h0D, 5'h00, 8'h00};
    v[10] = '{0, 5'h09, 8'h00, 8'h00, 0, 8'h3C, 1, 0, 2, 0, 0, 5'h00, 5'h00, 8'h00};
    v[11] = '{0, 5'h11, 8'h00, 8'h99, 0, 8'h99, 0, 0, 3, 1, 0, 5'h11, 5'h00, 8'h00};
    v[12] = '{0, 5'h15, 8'h00, 8'h44, 0, 8'h44, 0, 1, 5, 1, 1, 5'h15, 5'h09, 8'h3C};
    v[13] = '{1, 5'h0C, 8'hE7, 8'h00, 0, 8'h44, 0, 1, 3, 0, 1, 5'h00, 5'h04, 8'h22};
    v[14] = '{0, 5'h0C, 8'h00, 8'h00, 0, 8'hE7, 1, 0, 2, 0, 0, 5'h00, 5'h00, 8'h00};

    repeat (2) @(negedge clock);
    chk("ready_in_reset", {31'd0, cpu_ready}, 0);
    reset = 0;
    @(negedge clock);
    chk("rst.ready", {31'd0, cpu_ready}, 1);
    chk("rst.outs", {26'd0, cpu_done, hit, writeBack, mem_req, mem_we, 1'b0}, 0);
    chk("rst.rdata", {24'd0, cpu_rdata}, 0);
    chk("rst.maddr", {27'd0, mem_addr}, 0);
    chk("rst.mwdata", {24'd0, mem_wdata}, 0);
`ifdef CACHE_STATS_EN
    chk("rst.stats", {hit_count, miss_count}, 0);
`endif

    for (int i = 0; i < 15; i++) run($sformatf("v%0d", i), v[i]);

    // reset while waiting for a refill ack
    begin
      logic seen;
      vec_t t;
      seen = 0;
      cpu_req = 1; cpu_wren = 0; cpu_addr = 5'h1D;
      @(negedge clock);
      cpu_req = 0;
      for (int c = 0; c < 10 && !seen; c++) begin
        if (mem_req) seen = 1;
        else @(negedge clock);
      end
      chk("rr.refill_seen", {31'd0, seen}, 1);
      reset = 1;
      @(negedge clock);
      chk("rr.mem_req", {31'd0, mem_req}, 0);
      chk("rr.done", {31'd0, cpu_done}, 0);
      chk("rr.ready_in_reset", {31'd0, cpu_ready}, 0);
      reset = 0;
      @(negedge clock);
      chk("rr.ready", {31'd0, cpu_ready}, 1);
      chk("rr.outs", {28'd0, cpu_done, hit, writeBack, mem_req}, 0);
      chk("rr.rdata", {24'd0, cpu_rdata}, 0);
`ifdef CACHE_STATS_EN
      chk("rr.stats", {hit_count, miss_count}, 0);
`endif
      t = '{0, 5'h1D, 8'h00, 8'h66, 0, 8'h66, 0, 0, 3, 1, 0, 5'h1D, 5'h00, 8'h00};
      run("rr.miss", t);
      t = '{0, 5'h1D, 8'h00, 8'h00, 0, 8'h66, 1, 0, 2, 0, 0, 5'h00, 5'h00, 8'h00};
      run("rr.hit", t);
`ifdef CACHE_STATS_EN
      chk("stats.hit", hit_count, 1);
      chk("stats.miss", miss_count, 1);
`endif
      t = '{0, 5'h05, 8'h00, 8'hC3, 0, 8'hC3, 0, 0, 3, 1, 0, 5'h05, 5'h00, 8'h00};
      run("rr.flushed", t);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
